// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FPU command sequencer: states, opcodes,
// STATUS bit positions and the canonical half-precision quiet NaN.
package fpu_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RX_A_LO,
    RX_B_HI,
    RX_B_LO,
    RX_OP,
    ISSUE,
    WAIT,
    TX_HI,
    TX_LO,
    TX_STAT
  } seqState_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned ST_FPU_ERR = 0;
  localparam int unsigned ST_BAD_OP  = 1;
  localparam int unsigned ST_TIMEOUT = 2;
  localparam int unsigned ST_OVERRUN = 3;

  localparam logic [15:0] NAN_H = 16'h7E00;

  // Assemble the STATUS response byte from the individual flags.
  function automatic logic [7:0] packStatus(input logic overrun, input logic timeout,
                                            input logic badOp, input logic fpuErr);
    logic [7:0] s;
    s             = 8'h00;
    s[ST_OVERRUN] = overrun;
    s[ST_TIMEOUT] = timeout;
    s[ST_BAD_OP]  = badOp;
    s[ST_FPU_ERR] = fpuErr;
    return s;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable saturating down-counter; expired is registered and high once the
// count has reached zero.
module seq_timer #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] cntQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      cntQ    <= '0;
      expired <= 1'b1;
    end else if (load) begin
      cntQ    <= loadVal;
      expired <= (loadVal == '0);
    end else if (enable && (cntQ != '0)) begin
      cntQ    <= cntQ - W'(1);
      expired <= (cntQ == W'(1));
    end
  end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Byte-stream front end for a half-precision FPU: collects a 5-byte command
// frame, issues it to the core, and returns a 3-byte result/status response.
module fpu_cmd_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned IDLE_CYC    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [1:0]  op_code,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [15:0] fpu_result,
  input  logic        fpu_error,
  output logic        busy,
  output logic        frame_drop
);

  localparam int unsigned CntMax = (TIMEOUT_CYC > IDLE_CYC) ? TIMEOUT_CYC : IDLE_CYC;
  localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);

  seqState_e   stateQ, stateD;
  logic [15:0] opAD, opBD, resultQ, resultD;
  logic [1:0]  opCodeD;
  logic [7:0]  txDataD;
  logic        txValidD, fpuStartD, busyD, frameDropD;
  logic        overrunQ, overrunD, timeoutQ, timeoutD;
  logic        badOpQ, badOpD, fpuErrQ, fpuErrD;
  logic        cntLoad, cntEn, cntExpired;
  logic [CntW-1:0] cntLoadVal;
  logic        txFire, rxOverrun;

  // One counter serves both the inter-byte gap and the core response timeout.
  seq_timer #(.W(CntW)) uTimer (
    .clk     (clk),
    .rst     (rst),
    .load    (cntLoad),
    .loadVal (cntLoadVal),
    .enable  (cntEn),
    .expired (cntExpired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      fpu_start  <= 1'b0;
      busy       <= 1'b0;
      frame_drop <= 1'b0;
      resultQ    <= '0;
      overrunQ   <= 1'b0;
      timeoutQ   <= 1'b0;
      badOpQ     <= 1'b0;
      fpuErrQ    <= 1'b0;
    end else begin
      stateQ     <= stateD;
      op_a       <= opAD;
      op_b       <= opBD;
      op_code    <= opCodeD;
      tx_data    <= txDataD;
      tx_valid   <= txValidD;
      fpu_start  <= fpuStartD;
      busy       <= busyD;
      frame_drop <= frameDropD;
      resultQ    <= resultD;
      overrunQ   <= overrunD;
      timeoutQ   <= timeoutD;
      badOpQ     <= badOpD;
      fpuErrQ    <= fpuErrD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    opAD       = op_a;
    opBD       = op_b;
    opCodeD    = op_code;
    resultD    = resultQ;
    overrunD   = overrunQ;
    timeoutD   = timeoutQ;
    badOpD     = badOpQ;
    fpuErrD    = fpuErrQ;
    frameDropD = 1'b0;
    cntLoad    = 1'b0;
    cntLoadVal = CntW'(IDLE_CYC - 1);
    cntEn      = 1'b0;
    txFire     = tx_valid && tx_ready;
    rxOverrun  = rx_valid && (stateQ inside {ISSUE, WAIT, TX_HI, TX_LO, TX_STAT});

    if (rxOverrun) overrunD = 1'b1;

    unique case (stateQ)
      IDLE: begin
        if (rx_valid) begin
          opAD[15:8] = rx_data;
          cntLoad    = 1'b1;
          stateD     = RX_A_LO;
        end
      end
      RX_A_LO, RX_B_HI, RX_B_LO, RX_OP: begin
        // A byte arriving in the expiry cycle still belongs to the frame.
        if (rx_valid) begin
          cntLoad = 1'b1;
          unique case (stateQ)
            RX_A_LO: begin opAD[7:0]  = rx_data; stateD = RX_B_HI; end
            RX_B_HI: begin opBD[15:8] = rx_data; stateD = RX_B_LO; end
            RX_B_LO: begin opBD[7:0]  = rx_data; stateD = RX_OP;   end
            default: begin
              opCodeD = rx_data[1:0];
              if (rx_data[7:2] == 6'd0) begin
                stateD = ISSUE;
              end else begin
                badOpD  = 1'b1;
                resultD = NAN_H;
                stateD  = TX_HI;
              end
            end
          endcase
        end else if (cntExpired) begin
          frameDropD = 1'b1;
          stateD     = IDLE;
        end else begin
          cntEn = 1'b1;
        end
      end
      ISSUE: begin
        cntLoad    = 1'b1;
        cntLoadVal = CntW'(TIMEOUT_CYC - 1);
        stateD     = WAIT;
      end
      WAIT: begin
        // fpu_done takes priority over a timeout expiring in the same cycle.
        if (fpu_done) begin
          resultD = fpu_result;
          fpuErrD = fpu_error;
          stateD  = TX_HI;
        end else if (cntExpired) begin
          resultD  = NAN_H;
          timeoutD = 1'b1;
          stateD   = TX_HI;
        end else begin
          cntEn = 1'b1;
        end
      end
      TX_HI: if (txFire) stateD = TX_LO;
      TX_LO: if (txFire) stateD = TX_STAT;
      TX_STAT: begin
        if (txFire) begin
          overrunD = 1'b0;
          timeoutD = 1'b0;
          badOpD   = 1'b0;
          fpuErrD  = 1'b0;
          stateD   = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase

    fpuStartD = (stateD == ISSUE);
    busyD     = (stateD != IDLE);
    txValidD  = stateD inside {TX_HI, TX_LO, TX_STAT};

    // tx_data is loaded only on entry to a TX state so it holds while stalled.
    txDataD = tx_data;
    if (stateD != stateQ) begin
      case (stateD)
        TX_HI:   txDataD = resultD[15:8];
        TX_LO:   txDataD = resultD[7:0];
        TX_STAT: txDataD = packStatus(overrunD, timeoutD, badOpD, fpuErrD);
        default: txDataD = 8'h00;
      endcase
    end
  end

endmodule
